instr_mem: RTL and testbench

//  Parametrised instruction memory; successor of the fixed word ROM on the fetch path.

---
 rtl/instr_mem.sv | 152 +++++++++++++++
 tb/tb_instr_mem.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// Instruction memory: 1-cycle valid/ready fetch port with error flagging,
// plus an in-system byte-stream program loader that writes words little-endian.
//
// state | meaning
// RUN   | fetch port active, loader idle
// LOAD  | bytes assembled into words and written, fetch port stalled
module instr_mem #(
  parameter int          ADDR_WIDTH  = 15,
  parameter int          DEPTH_WORDS = 8192,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] ERR_WORD    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_end,
  output logic                  load_busy,
  output logic [ADDR_WIDTH-2:0] load_words,
  output logic                  load_err
);
  localparam logic S_RUN  = 1'b0;
  localparam logic S_LOAD = 1'b1;

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic          state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lerr_q, lerr_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic          fetch_bad;
  logic          accept;
  logic [31:0]   rd_word;
  logic [31:0]   lane_word;
  logic          commit;
  logic          we;
  logic [31:0]   wdata;

  // The word index is compared one bit wider so DEPTH_WORDS == 2**(ADDR_WIDTH-2) still fits.
  assign fetch_bad = (req_addr[1:0] != 2'b00) ||
                     ({1'b0, req_addr[ADDR_WIDTH-1:2]} >= DEPTH_C);
  assign rd_word   = mem[req_addr[IW+1:2]];
  assign req_ready = reset_n && (state_q == S_RUN) && (!rvalid_q || resp_ready);
  assign accept    = req_valid && req_ready;
  assign lane_word = asm_q | ({24'd0, load_byte} << {lane_q, 3'b000});

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    lerr_d  = lerr_q;
    commit  = 1'b0;
    we      = 1'b0;
    wdata   = load_valid ? lane_word : asm_q;

    // load_start wins over load_end and over any byte offered in the same cycle.
    if (load_start) begin
      state_d = S_LOAD;
      lane_d  = 2'd0;
      asm_d   = 32'd0;
      cnt_d   = '0;
      lerr_d  = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (load_valid) begin
        asm_d  = lane_word;
        lane_d = lane_q + 2'd1;
        commit = (lane_q == 2'd3);
      end
      if (load_end) begin
        state_d = S_RUN;
        if (load_valid ? (lane_q != 2'd3) : (lane_q != 2'd0)) commit = 1'b1;
      end
    end

    // Upper lanes of asm_q are always zero, so a partial word comes out zero-padded.
    if (commit) begin
      lane_d = 2'd0;
      asm_d  = 32'd0;
      if (cnt_q < DEPTH_C) begin
        we    = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end else begin
        lerr_d = 1'b1;
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    if (accept) begin
      rvalid_d = 1'b1;
      rerr_d   = fetch_bad;
      rdata_d  = fetch_bad ? ERR_WORD : rd_word;
    end else if (resp_ready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RUN;
      lane_q   <= 2'd0;
      asm_q    <= 32'd0;
      cnt_q    <= '0;
      lerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      lerr_q   <= lerr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[cnt_q[IW-1:0]] <= wdata;
  end

  assign resp_valid = rvalid_q;
  assign resp_data  = rdata_q;
  assign resp_err   = rerr_q;
  assign load_busy  = (state_q == S_LOAD);
  assign load_words = cnt_q;
  assign load_err   = lerr_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: fetch responses checked through a FIFO
// scoreboard, loader and reset behaviour checked inline per scenario task.
module tb_instr_mem;
  localparam int AW    = 10;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          load_start;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_end;
  logic          load_busy;
  logic [AW-2:0] load_words;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [0:DEPTH-1];
  logic [32:0] sb [$];

  instr_mem #(
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .INIT_FILE  (""),
    .ERR_WORD   (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_byte (load_byte),
    .load_end  (load_end),
    .load_busy (load_busy),
    .load_words(load_words),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] expect_for(input logic [AW-1:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    return bad ? {1'b1, 32'h0000_0013} : {1'b0, exp_mem[a[7:2]]};
  endfunction

  // Scoreboard: pop on response handshake, then push for a new accept.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_n && resp_valid && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_spurious got err=%b data=%h expected no response", resp_err, resp_data);
      end else begin
        e = sb.pop_front();
        if ({resp_err, resp_data} !== e) begin
          errors++;
          $display("FAIL sb_resp got err=%b data=%h expected err=%b data=%h",
                   resp_err, resp_data, e[32], e[31:0]);
        end
      end
    end
    if (reset_n && req_valid && req_ready) sb.push_back(expect_for(req_addr));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout addr=%h req_ready=%b expected 1", a, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic lbyte(input logic [7:0] b, input logic with_end);
    load_valid = 1'b1;
    load_byte  = b;
    load_end   = with_end;
    tick();
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_byte = '0; load_end = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_req_ready_low got %b expected 0", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, resp_data, load_busy, load_words, load_err} !== '0) begin
      errors++;
      $display("FAIL rst_outputs got v=%b e=%b d=%h busy=%b words=%0d lerr=%b expected all 0",
               resp_valid, resp_err, resp_data, load_busy, load_words, load_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_req_ready_high got %b expected 1", req_ready);
    end
  endtask

  task automatic test_load_small();
    pulse_start();
    @(negedge clk);
    checks++;
    if (load_busy !== 1'b1) begin
      errors++; $display("FAIL load_busy got %b expected 1", load_busy);
    end
    tick();
    lbyte(8'h13, 1'b0); lbyte(8'h05, 1'b0); lbyte(8'hA0, 1'b0); lbyte(8'h00, 1'b0);
    lbyte(8'hEF, 1'b0);
    pulse_end();
    exp_mem[0] = 32'h00A0_0513;
    exp_mem[1] = 32'h0000_00EF;
    @(negedge clk);
    checks++;
    if (load_words !== 9'd2 || load_busy !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_small got words=%0d busy=%b err=%b expected 2 0 0",
               load_words, load_busy, load_err);
    end
    tick();
    send(10'h004);
    send(10'h000);
    drain();
  endtask

  task automatic test_load_image();
    pulse_start();
    for (int w = 0; w < 16; w++) begin
      logic [31:0] v;
      v = $urandom;
      exp_mem[w] = v;
      for (int b = 0; b < 4; b++)
        lbyte(v[8*b +: 8], (w == 15) && (b == 3));
    end
    @(negedge clk);
    checks++;
    if (load_words !== 9'd16 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_end_with_byte got words=%0d busy=%b expected 16 0", load_words, load_busy);
    end
    tick();
    for (int w = 0; w < 16; w++) send(AW'(w * 4));
    drain();
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 10'h000;
    tick();
    resp_ready = 1'b0;
    req_addr   = 10'h004;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_data !== exp_mem[0]) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b d=%h expected 0 1 %h",
                 i, req_ready, resp_valid, resp_data, exp_mem[0]);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    req_addr = 10'h008;
    tick();
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_errors();
    resp_ready = 1'b1;
    send(10'h006);
    send(10'h001);
    send(AW'(DEPTH * 4));
    send(10'h3FC);
    send(AW'(DEPTH * 4 - 4));
    drain();
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int w = 0; w <= DEPTH; w++) begin
      logic [31:0] v;
      v = (w == DEPTH) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + 32'(w));
      if (w < DEPTH) exp_mem[w] = v;
      for (int b = 0; b < 4; b++) lbyte(v[8*b +: 8], 1'b0);
    end
    @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || load_words !== 9'(DEPTH)) begin
      errors++;
      $display("FAIL overflow got err=%b words=%0d expected 1 %0d", load_err, load_words, DEPTH);
    end
    tick();
    pulse_end();
    send(10'h000);
    send(AW'(DEPTH * 4 - 4));
    drain();
    pulse_start();
    @(negedge clk);
    checks++;
    if (load_err !== 1'b0 || load_words !== 9'd0 || load_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart got err=%b words=%0d busy=%b expected 0 0 1", load_err, load_words, load_busy);
    end
    tick();
    load_start = 1'b1; load_end = 1'b1;
    tick();
    load_start = 1'b0; load_end = 1'b0;
    @(negedge clk);
    checks++;
    if (load_busy !== 1'b1) begin
      errors++; $display("FAIL start_and_end got busy=%b expected 1", load_busy);
    end
    tick();
    pulse_end();
    pulse_end();
    @(negedge clk);
    checks++;
    if (load_busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL end_in_run got busy=%b rdy=%b expected 0 1", load_busy, req_ready);
    end
    tick();
  endtask

  task automatic test_start_pending();
    resp_ready = 1'b0;
    send(10'h008);
    pulse_start();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp_mem[2] || req_ready !== 1'b0 || load_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_pending got v=%b d=%h rdy=%b busy=%b expected 1 %h 0 1",
               resp_valid, resp_data, req_ready, load_busy, exp_mem[2]);
    end
    tick();
    resp_ready = 1'b1;
    tick();
    pulse_end();
    drain();
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    lbyte(8'h11, 1'b0); lbyte(8'h22, 1'b0); lbyte(8'h33, 1'b0);
    lbyte(8'h44, 1'b0); lbyte(8'h55, 1'b0); lbyte(8'h66, 1'b0);
    exp_mem[0] = 32'h4433_2211;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_data, load_busy, load_words, load_err, req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_load got v=%b e=%b d=%h busy=%b words=%0d lerr=%b rdy=%b expected all 0",
               resp_valid, resp_err, resp_data, load_busy, load_words, load_err, req_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || load_busy !== 1'b0) begin
      errors++; $display("FAIL rst_release got rdy=%b busy=%b expected 1 0", req_ready, load_busy);
    end
    tick();
    send(10'h000);
    send(10'h004);
    drain();
  endtask

  initial begin
    test_reset();
    tick();
    test_load_small();
    test_load_image();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_start_pending();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
